// File: rtl/nn_wb_csr_bridge.sv
// Wishbone CSR front end for the NN inference core: operand bank, control and
// status registers, a launch/wait sequencer with timeout, and a result FIFO.
module nn_wb_csr_bridge #(
  parameter int          N_OPERANDS     = 6,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [37:0]               io_in,
  output logic [37:0]               io_out,
  output logic [37:0]               io_oeb,
  output logic [32*N_OPERANDS-1:0]  core_operands,
  output logic                      core_in_valid,
  input  logic [31:0]               core_result,
  input  logic                      core_out_valid
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] FIFO_FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t                        state;
  logic [TW-1:0]                 tmo_cnt;
  logic                          timeout_flag;
  logic                          overflow_flag;
  logic                          sw_en;
  logic [31:0]                   last_result;
  logic [N_OPERANDS-1:0][31:0]   operands;
  logic [31:0]                   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 rd_ptr;
  logic [CW-1:0]                 fifo_count;
  logic [2:0]                    sw_sync;

  logic        in_window;
  logic        xfer;
  logic        wr_xfer;
  logic        rd_xfer;
  logic [9:0]  word;
  logic [9:0]  op_off;
  logic        is_op;
  logic        busy;
  logic        ctrl_wr;
  logic        start_wr;
  logic        clr_flags;
  logic        flush;
  logic        op_wr;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        sw_rise;
  logic        launch_req;
  logic        result_acc;
  logic        do_push;
  logic        overflow_evt;
  logic [31:0] status_word;
  logic [31:0] rd_data;
  logic        unused_bits;

  // Bus decode: a transfer is a fresh strobe inside our 4 KiB window; the
  // ack-low qualifier makes back-to-back strobes take every other cycle.
  assign in_window = (wbs_adr_i & 32'hFFFF_F000) == BASE_ADDR;
  assign xfer      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & in_window;
  assign wr_xfer   = xfer & wbs_we_i;
  assign rd_xfer   = xfer & ~wbs_we_i;
  assign word      = wbs_adr_i[11:2];
  assign op_off    = word - 10'd4;
  assign is_op     = (word >= 10'd4) && (op_off < 10'(N_OPERANDS));

  assign busy       = (state != ST_IDLE);
  assign ctrl_wr    = wr_xfer & (word == 10'd0) & wbs_sel_i[0];
  assign start_wr   = ctrl_wr & wbs_dat_i[0];
  assign clr_flags  = ctrl_wr & wbs_dat_i[2];
  assign flush      = ctrl_wr & wbs_dat_i[3];
  assign op_wr      = wr_xfer & is_op & ~busy;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
  assign pop        = rd_xfer & (word == 10'd2) & ~fifo_empty;

  assign sw_rise    = sw_sync[1] & ~sw_sync[2];
  assign launch_req = start_wr | (sw_en & sw_rise);
  assign result_acc = (state == ST_WAIT) & core_out_valid;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push      = result_acc & (~fifo_full | pop);
  assign overflow_evt = result_acc & fifo_full & ~pop;

  assign status_word = {16'h0, 8'(fifo_count), 3'b000, timeout_flag,
                        overflow_flag, fifo_full, fifo_empty, busy};

  assign core_operands = operands;
  assign io_out        = {6'h00, last_result};
  assign io_oeb        = {6'h3F, 32'h0};

  assign unused_bits = ^{io_in[37:33], io_in[31:0], wbs_adr_i[1:0]};

  // Read-data selection for the register addressed in the current transfer.
  always_comb begin
    rd_data = 32'h0;
    case (word)
      10'd0:   rd_data = {30'h0, sw_en, 1'b0};
      10'd1:   rd_data = status_word;
      10'd2:   rd_data = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
      10'd3:   rd_data = last_result;
      default: begin
        for (int i = 0; i < N_OPERANDS; i++) begin
          if (is_op && (op_off == 10'(i))) rd_data = operands[i];
        end
      end
    endcase
  end

  // Registered acknowledge; read data is only non-zero alongside a read ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= xfer;
      wbs_dat_o <= rd_xfer ? rd_data : 32'h0;
    end
  end

  // Switch input: two synchroniser flops followed by the edge-history flop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sw_sync <= 3'b000;
    end else begin
      sw_sync <= {sw_sync[1:0], io_in[32]};
    end
  end

  // The only persistent CTRL bit is the switch-launch enable.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sw_en <= 1'b0;
    end else if (ctrl_wr) begin
      sw_en <= wbs_dat_i[1];
    end
  end

  // Operand bank with byte enables; frozen while the core is working.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      operands <= '0;
    end else begin
      for (int i = 0; i < N_OPERANDS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (op_wr && (op_off == 10'(i)) && wbs_sel_i[b]) begin
            operands[i][8*b +: 8] <= wbs_dat_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Launch/wait sequencer; a timeout set in the same cycle as a clear wins.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      core_in_valid <= 1'b0;
      tmo_cnt       <= '0;
      timeout_flag  <= 1'b0;
    end else begin
      core_in_valid <= 1'b0;
      if (clr_flags) timeout_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_req) begin
            state         <= ST_LAUNCH;
            core_in_valid <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state   <= ST_WAIT;
          tmo_cnt <= '0;
        end
        ST_WAIT: begin
          if (core_out_valid) begin
            state <= ST_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
            state        <= ST_IDLE;
            timeout_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and overflow flag; flush overrides push and pop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (clr_flags)    overflow_flag <= 1'b0;
      if (overflow_evt) overflow_flag <= 1'b1;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(do_push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge wb_clk_i) begin
    if (do_push && !flush) fifo_mem[wr_ptr] <= core_result;
  end

  // Most recent accepted result, kept even when the FIFO drops it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_result <= 32'h0;
    end else if (result_acc) begin
      last_result <= core_result;
    end
  end

endmodule

// File: tb/tb_nn_wb_csr_bridge.sv
// Scoreboard bench for nn_wb_csr_bridge: tasks drive Wishbone, switch and core
// stimulus while a behavioural register/FIFO model predicts every read ack and
// every launch; a negedge monitor pops and compares those predictions.
module tb_nn_wb_csr_bridge;

  localparam int          N_OPS = 6;
  localparam int          DEPTH = 8;
  localparam int          TMO   = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic                  wb_clk_i;
  logic                  wb_rst_i;
  logic                  wbs_stb_i;
  logic                  wbs_cyc_i;
  logic                  wbs_we_i;
  logic [3:0]            wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [31:0]           wbs_dat_i;
  logic                  wbs_ack_o;
  logic [31:0]           wbs_dat_o;
  logic [37:0]           io_in;
  logic [37:0]           io_out;
  logic [37:0]           io_oeb;
  logic [32*N_OPS-1:0]   core_operands;
  logic                  core_in_valid;
  logic [31:0]           core_result;
  logic                  core_out_valid;

  nn_wb_csr_bridge #(
    .N_OPERANDS(N_OPS),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .io_in(io_in),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .core_operands(core_operands),
    .core_in_valid(core_in_valid),
    .core_result(core_result),
    .core_out_valid(core_out_valid)
  );

  int errors = 0;
  int checks = 0;
  int launches_seen = 0;
  int launch_target = 0;

  // Behavioural model of the programmer-visible state.
  logic [31:0]  m_ops [N_OPS];
  logic         m_sw_en;
  logic         m_busy;
  logic         m_ovf;
  logic         m_tmo;
  logic [31:0]  m_last;
  logic [31:0]  m_fifo [$];

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [31:0]          exp_rd_q [$];
  string                exp_name_q [$];
  logic [32*N_OPS-1:0]  exp_launch_q [$];

  logic [31:0]          mon_rd;
  string                mon_name;
  logic [32*N_OPS-1:0]  mon_ops;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every ack and every launch pulse must match a queued prediction.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (wbs_ack_o) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got ack with data %0h, expected no ack", wbs_dat_o);
        end else begin
          mon_rd   = exp_rd_q.pop_front();
          mon_name = exp_name_q.pop_front();
          checkOutput(mon_name, {160'h0, wbs_dat_o}, {160'h0, mon_rd});
        end
      end
      if (core_in_valid) begin
        launches_seen++;
        if (exp_launch_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_launch: got core_in_valid, expected none");
        end else begin
          mon_ops = exp_launch_q.pop_front();
          checkOutput("launch_operands", core_operands, mon_ops);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [32*N_OPS-1:0] pack_ops();
    logic [32*N_OPS-1:0] r;
    r = '0;
    for (int i = 0; i < N_OPS; i++) r[32*i +: 32] = m_ops[i];
    return r;
  endfunction

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = 32'h0;
    s[0]    = m_busy;
    s[1]    = (m_fifo.size() == 0);
    s[2]    = (m_fifo.size() == DEPTH);
    s[3]    = m_ovf;
    s[4]    = m_tmo;
    s[15:8] = 8'(m_fifo.size());
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OPS; i++) m_ops[i] = 32'h0;
    m_sw_en = 1'b0;
    m_busy  = 1'b0;
    m_ovf   = 1'b0;
    m_tmo   = 1'b0;
    m_last  = 32'h0;
    m_fifo.delete();
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string name);
    exp_rd_q.push_back(exp);
    exp_name_q.push_back(name);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    step();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    step();
  endtask

  task automatic wb_no_ack(input logic [31:0] adr);
    int acks;
    acks = 0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = adr;
    wbs_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    step();
    checkOutput("outside_window_acks", 192'(acks), 192'd0);
  endtask

  task automatic write_ctrl(input logic [31:0] dat, input logic [3:0] sel);
    if (sel[0]) begin
      if (dat[0] && !m_busy) begin
        exp_launch_q.push_back(pack_ops());
        launch_target++;
        m_busy = 1'b1;
      end
      m_sw_en = dat[1];
      if (dat[2]) begin
        m_ovf = 1'b0;
        m_tmo = 1'b0;
      end
      if (dat[3]) m_fifo.delete();
    end
    wb_xfer(1'b1, BASE, dat, sel, 32'h0, "ctrl_write_ack");
  endtask

  task automatic write_op(input int idx, input logic [31:0] dat, input logic [3:0] sel);
    if (!m_busy) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) m_ops[idx][8*b +: 8] = dat[8*b +: 8];
      end
    end
    wb_xfer(1'b1, BASE + 32'(16 + 4*idx), dat, sel, 32'h0, "operand_write_ack");
  endtask

  task automatic read_reg(input int word, input string name);
    logic [31:0] exp;
    exp = 32'h0;
    if (word == 0) exp = {30'h0, m_sw_en, 1'b0};
    else if (word == 1) exp = status_exp();
    else if (word == 2) begin
      if (m_fifo.size() > 0) exp = m_fifo.pop_front();
    end
    else if (word == 3) exp = m_last;
    else if (word >= 4 && word < 4 + N_OPS) exp = m_ops[word-4];
    wb_xfer(1'b0, BASE + 32'(4*word), $urandom, 4'hF, exp, name);
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    while (launches_seen < launch_target && n < 20) begin
      step();
      n++;
    end
    checkOutput("launch_seen_count", 192'(launches_seen), 192'(launch_target));
  endtask

  task automatic model_accept(input logic [31:0] v);
    if (m_busy) begin
      m_last = v;
      if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
      else m_fifo.push_back(v);
      m_busy = 1'b0;
    end
  endtask

  task automatic core_respond(input logic [31:0] v);
    model_accept(v);
    core_result    = v;
    core_out_valid = 1'b1;
    step();
    core_out_valid = 1'b0;
    core_result    = $urandom;
    checkOutput("io_out_last_result", {154'h0, io_out}, {154'h0, 6'h00, m_last});
  endtask

  task automatic launch_and_respond(input logic [31:0] v);
    write_ctrl({30'h0, m_sw_en, 1'b1}, 4'h1);
    wait_launch();
    core_respond(v);
  endtask

  task automatic result_read_with_push(input logic [31:0] v);
    logic [31:0] exp;
    exp = (m_fifo.size() > 0) ? m_fifo.pop_front() : 32'h0;
    model_accept(v);
    exp_rd_q.push_back(exp);
    exp_name_q.push_back("result_pop_with_push");
    wbs_cyc_i      = 1'b1;
    wbs_stb_i      = 1'b1;
    wbs_we_i       = 1'b0;
    wbs_adr_i      = BASE + 32'h8;
    wbs_sel_i      = 4'hF;
    core_result    = v;
    core_out_valid = 1'b1;
    step();
    wbs_cyc_i      = 1'b0;
    wbs_stb_i      = 1'b0;
    core_out_valid = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ack"}, {191'h0, wbs_ack_o}, 192'h0);
    checkOutput({tag, "_dat"}, {160'h0, wbs_dat_o}, 192'h0);
    checkOutput({tag, "_core_in_valid"}, {191'h0, core_in_valid}, 192'h0);
    checkOutput({tag, "_operands"}, core_operands, 192'h0);
    checkOutput({tag, "_io_out"}, {154'h0, io_out}, 192'h0);
    checkOutput({tag, "_io_oeb"}, {154'h0, io_oeb}, {154'h0, 6'h3F, 32'h0});
  endtask

  task automatic applyStimulus();
    logic [31:0] v;
    int          op;
    int          idx;

    // Power-on reset.
    check_reset_outputs("reset");
    wb_rst_i = 1'b0;
    step();
    read_reg(1, "status_after_reset");
    read_reg(0, "ctrl_after_reset");
    read_reg(3, "last_after_reset");

    // Basic launch with operands 1..6.
    for (int i = 0; i < N_OPS; i++) write_op(i, 32'(i + 1), 4'hF);
    for (int i = 0; i < N_OPS; i++) read_reg(4 + i, "operand_readback");
    launch_and_respond(32'h3F80_0000);
    read_reg(2, "result_basic");
    read_reg(1, "status_after_basic");

    // Decode corners: unmapped words, outside window, CTRL with sel[0] low.
    read_reg(256, "unmapped_read");
    wb_xfer(1'b1, BASE + 32'h28, 32'hDEAD_BEEF, 4'hF, 32'h0, "unmapped_write_ack");
    read_reg(4 + N_OPS, "beyond_operands_read");
    wb_no_ack(BASE + 32'h0000_1000);
    wb_no_ack(32'h2000_0004);
    write_ctrl(32'h0000_0001, 4'h2);
    step();
    step();
    read_reg(1, "status_after_sel0_start");
    read_reg(2, "result_empty_read");

    // Randomised register traffic against the model.
    for (int it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 5);
      idx = $urandom_range(0, N_OPS - 1);
      case (op)
        0: write_op(idx, $urandom, 4'($urandom_range(0, 15)));
        1: read_reg(4 + idx, "rand_operand_read");
        2: begin
          write_ctrl({30'h0, m_sw_en, 1'b1}, 4'h1);
          wait_launch();
          if ($urandom_range(0, 1) == 1) write_op(idx, $urandom, 4'hF);
          if ($urandom_range(0, 1) == 1) write_ctrl({30'h0, m_sw_en, 1'b1}, 4'h1);
          core_respond($urandom);
        end
        3: read_reg(2, "rand_result_read");
        4: read_reg(1, "rand_status_read");
        default: read_reg(3, "rand_last_read");
      endcase
    end

    // Flush and clear, then overflow with nine results.
    write_ctrl(32'h0000_000C, 4'h1);
    read_reg(1, "status_after_flush");
    for (int k = 1; k <= 9; k++) launch_and_respond(32'(k));
    read_reg(1, "status_overflow");
    for (int k = 0; k < DEPTH; k++) read_reg(2, "overflow_drain");
    read_reg(3, "last_after_overflow");
    write_ctrl(32'h0000_0004, 4'h1);
    read_reg(1, "status_after_clear");

    // Full FIFO with a pop and a push in the same cycle.
    for (int k = 0; k < DEPTH; k++) launch_and_respond($urandom);
    write_ctrl(32'h0000_0001, 4'h1);
    wait_launch();
    v = $urandom;
    result_read_with_push(v);
    read_reg(1, "status_full_pushpop");
    for (int k = 0; k < DEPTH; k++) read_reg(2, "pushpop_drain");
    read_reg(2, "result_after_drain");

    // Timeout: still busy in the last WAIT cycle, idle one cycle later.
    write_ctrl(32'h0000_0001, 4'h1);
    wait_launch();
    for (int k = 0; k < TMO - 1; k++) step();
    read_reg(1, "status_last_wait_cycle");
    m_busy = 1'b0;
    m_tmo  = 1'b1;
    read_reg(1, "status_timeout_set");
    write_ctrl(32'h0000_0004, 4'h1);
    read_reg(1, "status_timeout_cleared");
    write_ctrl(32'h0000_0001, 4'h1);
    wait_launch();
    for (int k = 0; k < TMO; k++) step();
    m_busy = 1'b0;
    m_tmo  = 1'b1;
    read_reg(1, "status_first_idle_cycle");
    core_respond(32'h1234_5678);
    read_reg(1, "status_late_result_ignored");
    write_ctrl(32'h0000_0004, 4'h1);

    // Switch launches: one per rising edge; START while busy is dropped.
    write_ctrl(32'h0000_0002, 4'h1);
    for (int k = 0; k < 3; k++) begin
      exp_launch_q.push_back(pack_ops());
      launch_target++;
      m_busy = 1'b1;
      io_in[32] = 1'b1;
      wait_launch();
      write_ctrl(32'h0000_0003, 4'h1);
      core_respond($urandom);
      io_in[32] = 1'b0;
      for (int s = 0; s < 6; s++) step();
    end
    write_ctrl(32'h0000_0000, 4'h1);
    io_in[32] = 1'b1;
    for (int s = 0; s < 8; s++) step();
    io_in[32] = 1'b0;
    for (int s = 0; s < 4; s++) step();
    read_reg(1, "status_after_switch");

    // Reset during WAIT aborts everything.
    write_op(0, 32'hCAFE_F00D, 4'hF);
    write_ctrl(32'h0000_0001, 4'h1);
    wait_launch();
    wb_rst_i = 1'b1;
    model_reset();
    step();
    check_reset_outputs("midwait_reset");
    step();
    wb_rst_i = 1'b0;
    step();
    core_respond(32'h5555_AAAA);
    read_reg(1, "status_after_midwait_reset");
    read_reg(3, "last_after_midwait_reset");
    read_reg(4, "operand_after_midwait_reset");
    read_reg(2, "result_after_midwait_reset");
  endtask

  initial begin
    wb_rst_i       = 1'b1;
    wbs_stb_i      = 1'b0;
    wbs_cyc_i      = 1'b0;
    wbs_we_i       = 1'b0;
    wbs_sel_i      = 4'h0;
    wbs_adr_i      = 32'h0;
    wbs_dat_i      = 32'h0;
    io_in          = 38'h0;
    core_result    = 32'h0;
    core_out_valid = 1'b0;
    model_reset();
    step();
    step();
    step();
    applyStimulus();
    step();
    step();
    checkOutput("pending_reads", 192'(exp_rd_q.size()), 192'd0);
    checkOutput("pending_launches", 192'(exp_launch_q.size()), 192'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
